proc_io_sched: RTL

//   Input/output scheduler for the zero-cross processor wrapper.
//   - Buffers two sample streams in per-channel FIFOs and drives the FIFO heads onto the processor's in0/in1.
//   - Pops a FIFO when the processor reads that channel (req_in).
//   - Raises the processor interrupt (itr) once a full frame is buffered on both channels.
//   - Watches out_en to detect the end of a frame.

---
 rtl/sapho_io_pkg.sv | 17 +
 rtl/proc_io_sched_fifo.sv | 56 +++++
 rtl/proc_io_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sapho_io_pkg.sv
// Shared types and constants for the zero-cross processor I/O scheduler.
//   - state_t      : scheduler FSM states
//   - DATA_W_DEF   : default sample width
//   - CH0 / CH1    : channel indices into per-channel packed vectors
package sapho_io_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_CH     = 2;
  localparam int CH0        = 0;
  localparam int CH1        = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/proc_io_sched_fifo.sv
// sync_fifo: single-clock FIFO, one per scheduler channel.
// Ports:
//   clk, rst  clock, async active-high reset (pointers/count only)
//   push/din  write strobe and data; ignored when full
//   pop       read strobe; ignored when empty
//   dout      current head (raw storage, not masked when empty)
//   count     occupancy, log2(FIFO_DEPTH)+1 bits
//   full/empty occupancy flags
module sync_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             din,
  output logic [DATA_W-1:0]             dout,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  // Full FIFO: the pop still goes through, the push is dropped.
  assign do_push = push & ~full;
  assign do_pop  = pop  & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; count/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/proc_io_sched.sv
// proc_io_sched: input/output scheduler for the zero-cross processor wrapper.
// Buffers two sample streams, presents FIFO heads on in0/in1, fires itr when
// a full frame is buffered on both channels, and waits for the last output
// strobe (out_en[N_OUT-1]) to end the frame.
// Ports:
//   clk, rst                 clock, async active-high reset
//   s0_*/s1_*                sample streams (data, valid, ready = not full)
//   req_in[1:0]              processor read strobes (pop ch0/ch1)
//   out_en[N_OUT-1:0]        processor write strobes
//   in0, in1                 FIFO heads, 0 when empty
//   itr, frame_done          one-cycle pulses (FIRE / DONE states)
//   busy                     FSM not IDLE
//   err_clr                  clears sticky ovf/unf/timeout (set wins)
//   ovf, unf, timeout        sticky error flags
// Build option: define WDOG_EN to add the RUN-state watchdog (WDOG_CYC cycles);
// without it timeout is tied 0.
module proc_io_sched
  import sapho_io_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 8,
  parameter int N_OUT      = 5,
  parameter int WDOG_CYC   = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [1:0]        req_in,
  input  logic [N_OUT-1:0]  out_en,
  output logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] in1,
  output logic              itr,
  output logic              frame_done,
  output logic              busy,
  input  logic              err_clr,
  output logic [1:0]        ovf,
  output logic [1:0]        unf,
  output logic              timeout
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CH-1:0][DATA_W-1:0] din, dout;
  logic [NUM_CH-1:0][CW-1:0]     cnt;
  logic [NUM_CH-1:0]             valid, full, empty;
  logic                          last_wr, wdog_hit;
  state_t                        state, state_n;

  assign din[CH0]   = s0_data;
  assign din[CH1]   = s1_data;
  assign valid      = {s1_valid, s0_valid};
  assign s0_ready   = ~full[CH0];
  assign s1_ready   = ~full[CH1];
  assign in0        = empty[CH0] ? '0 : dout[CH0];
  assign in1        = empty[CH1] ? '0 : dout[CH1];

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (valid[ch]),
      .pop   (req_in[ch]),
      .din   (din[ch]),
      .dout  (dout[ch]),
      .count (cnt[ch]),
      .full  (full[ch]),
      .empty (empty[ch])
    );
  end

  // Sticky errors: a set in the same cycle as err_clr wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= '0;
      unf <= '0;
    end else begin
      ovf <= (ovf & {2{~err_clr}}) | (valid  & full);
      unf <= (unf & {2{~err_clr}}) | (req_in & empty);
    end
  end

  assign last_wr = out_en[N_OUT-1];

`ifdef WDOG_EN
  logic [15:0] wdog_cnt;
  // A last write in the expiry cycle completes the frame normally.
  assign wdog_hit = (state == RUN) && !last_wr && (wdog_cnt == 16'(WDOG_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (state == FIRE)     wdog_cnt <= '0;
      else if (state == RUN) wdog_cnt <= wdog_cnt + 1'b1;
      timeout <= (timeout & ~err_clr) | wdog_hit;
    end
  end
`else
  assign wdog_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (cnt[CH0] >= CW'(FRAME_LEN) && cnt[CH1] >= CW'(FRAME_LEN)) state_n = FIRE;
      FIRE: state_n = RUN;
      RUN:  if (last_wr)       state_n = DONE;
            else if (wdog_hit) state_n = IDLE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign itr        = (state == FIRE);
  assign frame_done = (state == DONE);
  assign busy       = (state != IDLE);
endmodule
